// File: rtl/io_output_if.sv
// CPU-side store interface of the output unit: write strobes from the IO
// address decoder plus the store data bus.
interface io_output_if;
    logic        led_ctrl;
    logic        seg_ctrl;
    logic [31:0] write_data;

    modport master (
        output led_ctrl,
        output seg_ctrl,
        output write_data
    );

    modport slave (
        input led_ctrl,
        input seg_ctrl,
        input write_data
    );
endinterface

// File: rtl/io_output_unit.sv
// Output-space write responder: latches CPU stores into the LED and segment
// registers, drives the LEDs, and scans the 8-digit hex display.
module io_output_unit #(
    parameter int LED_WIDTH = 16,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_LZ  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_output_if.slave           bus,
    output logic [LED_WIDTH-1:0] led,
    output logic [7:0]           seg_an,
    output logic [7:0]           seg_out
);

    localparam int             CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [LED_WIDTH-1:0] led_q,       led_d;
    logic [31:0]          seg_q,       seg_d;
    logic [CNT_W-1:0]     scan_cnt_q,  scan_cnt_d;
    logic [2:0]           digit_idx_q, digit_idx_d;
    logic [7:0]           seg_an_q,    seg_an_d;
    logic [7:0]           seg_out_q,   seg_out_d;

    logic [2:0]           msd_s;
    logic [3:0]           nibble_s;
    logic                 blank_s;

    // Hex digit to active-high gfedcba segment pattern.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0:    p = 7'h3F;
            4'h1:    p = 7'h06;
            4'h2:    p = 7'h5B;
            4'h3:    p = 7'h4F;
            4'h4:    p = 7'h66;
            4'h5:    p = 7'h6D;
            4'h6:    p = 7'h7D;
            4'h7:    p = 7'h07;
            4'h8:    p = 7'h7F;
            4'h9:    p = 7'h6F;
            4'hA:    p = 7'h77;
            4'hB:    p = 7'h7C;
            4'hC:    p = 7'h39;
            4'hD:    p = 7'h5E;
            4'hE:    p = 7'h79;
            4'hF:    p = 7'h71;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Most significant nonzero nibble; a zero register reports digit 0.
    always_comb begin
        msd_s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (seg_q[4*i +: 4] != 4'd0) begin
                msd_s = 3'(i);
            end else begin
                msd_s = msd_s;
            end
        end
    end

    // Next-state logic: store latching, scan timing and display decode.
    always_comb begin
        led_d       = led_q;
        seg_d       = seg_q;
        scan_cnt_d  = scan_cnt_q;
        digit_idx_d = digit_idx_q;
        seg_an_d    = 8'hFF;
        seg_out_d   = 8'hFF;
        nibble_s    = seg_q[{digit_idx_q, 2'b00} +: 4];
        blank_s     = (BLANK_LZ != 0) && (digit_idx_q > msd_s);

        if (bus.led_ctrl) begin
            led_d = bus.write_data[LED_WIDTH-1:0];
        end else begin
            led_d = led_q;
        end

        if (bus.seg_ctrl) begin
            seg_d = bus.write_data;
        end else begin
            seg_d = seg_q;
        end

        if (scan_cnt_q == CNT_MAX) begin
            scan_cnt_d  = {CNT_W{1'b0}};
            digit_idx_d = digit_idx_q + 3'd1;
        end else begin
            scan_cnt_d  = scan_cnt_q + CNT_W'(1);
            digit_idx_d = digit_idx_q;
        end

        // Display follows the register contents of the current digit, so a
        // store shows up one cycle after it is latched.
        if (blank_s) begin
            seg_an_d  = 8'hFF;
            seg_out_d = 8'hFF;
        end else begin
            seg_an_d  = ~(8'b0000_0001 << digit_idx_q);
            seg_out_d = {1'b1, ~hex7(nibble_s)};
        end
    end

    // State and registered outputs; reset leaves the display dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q       <= {LED_WIDTH{1'b0}};
            seg_q       <= 32'h0000_0000;
            scan_cnt_q  <= {CNT_W{1'b0}};
            digit_idx_q <= 3'd0;
            seg_an_q    <= 8'hFF;
            seg_out_q   <= 8'hFF;
        end else begin
            led_q       <= led_d;
            seg_q       <= seg_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            seg_an_q    <= seg_an_d;
            seg_out_q   <= seg_out_d;
        end
    end

    assign led     = led_q;
    assign seg_an  = seg_an_q;
    assign seg_out = seg_out_q;

endmodule

// File: tb/tb_io_output_unit.sv
// Scoreboard bench for io_output_unit: a behavioural model predicts every
// cycle's outputs for a blanking and a non-blanking instance.
module tb_io_output_unit;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] led,    led_nb;
    logic [7:0]  seg_an, seg_an_nb;
    logic [7:0]  seg_out, seg_out_nb;

    io_output_if bus ();

    io_output_unit #(.LED_WIDTH(16), .SCAN_DIV(DIV), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .led(led), .seg_an(seg_an), .seg_out(seg_out)
    );

    io_output_unit #(.LED_WIDTH(16), .SCAN_DIV(DIV), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .led(led_nb), .seg_an(seg_an_nb), .seg_out(seg_out_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] led;
        logic [7:0]  an;
        logic [7:0]  out;
        logic [7:0]  an_nb;
        logic [7:0]  out_nb;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0] scan_lit [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    logic [7:0] cap [8];

    // model state
    logic [15:0] m_led;
    logic [31:0] m_seg;
    int          m_cnt;
    logic [2:0]  m_idx;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict outputs after the coming edge and advance the model.
    task automatic model_step(input logic lc, input logic sc, input logic [31:0] wd);
        exp_t       e;
        int         msd;
        logic [3:0] nib;
        logic [7:0] an_full, out_full, one_hot;
        if (!rst_n) begin
            m_led = 16'h0; m_seg = 32'h0; m_cnt = 0; m_idx = 3'd0;
            e = '{16'h0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        end else begin
            msd = 0;
            for (int i = 0; i < 8; i++) if (m_seg[4*i +: 4] != 4'h0) msd = i;
            nib      = m_seg[4*m_idx +: 4];
            one_hot  = 8'b0000_0001 << m_idx;
            an_full  = ~one_hot;
            out_full = {1'b1, ~seg_tab[nib]};
            e.an_nb  = an_full;
            e.out_nb = out_full;
            e.an     = (int'(m_idx) > msd) ? 8'hFF : an_full;
            e.out    = (int'(m_idx) > msd) ? 8'hFF : out_full;
            if (lc) m_led = wd[15:0];
            if (sc) m_seg = wd;
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = m_idx + 3'd1;
            end else begin
                m_cnt = m_cnt + 1;
            end
            e.led = m_led;
        end
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, then pop and compare the prediction.
    task automatic cycle(input logic lc, input logic sc, input logic [31:0] wd);
        exp_t e;
        bus.led_ctrl   = lc;
        bus.seg_ctrl   = sc;
        bus.write_data = wd;
        model_step(lc, sc, wd);
        @(posedge clk);
        #1;
        bus.led_ctrl = 1'b0;
        bus.seg_ctrl = 1'b0;
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("led",        {16'h0, led},     {16'h0, e.led});
            check_val("seg_an",     {24'h0, seg_an},  {24'h0, e.an});
            check_val("seg_out",    {24'h0, seg_out}, {24'h0, e.out});
            check_val("seg_an_nb",  {24'h0, seg_an_nb},  {24'h0, e.an_nb});
            check_val("seg_out_nb", {24'h0, seg_out_nb}, {24'h0, e.out_nb});
            check_val("led_nb",     {16'h0, led_nb},  {16'h0, e.led});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [7:0] oh;
        int         waited;
        rst_n = 1'b1;
        bus.led_ctrl = 1'b0; bus.seg_ctrl = 1'b0; bus.write_data = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        check_val("reset_led", {16'h0, led}, 32'h0);
        check_val("reset_an",  {24'h0, seg_an}, 32'hFF);
        check_val("reset_out", {24'h0, seg_out}, 32'hFF);
        idle(2);

        rst_n = 1'b1;
        idle(1);
        check_val("rel_an",  {24'h0, seg_an},  32'hFE);
        check_val("rel_out", {24'h0, seg_out}, 32'hC0);
        idle(5);

        // LED writes
        cycle(1'b1, 1'b0, 32'hABCD_1234);
        check_val("led_1234", {16'h0, led}, 32'h1234);
        idle(3);
        cycle(1'b1, 1'b0, 32'h0);
        check_val("led_zero", {16'h0, led}, 32'h0);
        idle(2);

        // full scan with literal digit table
        cycle(1'b0, 1'b1, 32'h89AB_CDEF);
        for (int i = 0; i < 40; i++) begin
            idle(1);
            for (int d = 0; d < 8; d++) begin
                oh = 8'b0000_0001 << d;
                if (seg_an == ~oh) cap[d] = seg_out;
            end
        end
        for (int d = 0; d < 8; d++) check_val($sformatf("scan_d%0d", d), {24'h0, cap[d]}, {24'h0, scan_lit[d]});

        // leading-zero blanking
        cycle(1'b0, 1'b1, 32'h0000_0120);
        idle(36);
        cycle(1'b0, 1'b1, 32'h0);
        idle(36);

        // simultaneous and back-to-back strobes
        cycle(1'b1, 1'b1, 32'h0000_0005);
        check_val("led_5", {16'h0, led}, 32'h5);
        idle(34);
        cycle(1'b0, 1'b1, 32'h1);
        cycle(1'b0, 1'b1, 32'h2);
        idle(34);

        // write while digit 3 is active
        cycle(1'b0, 1'b1, 32'h0000_5000);
        waited = 0;
        while (!(m_idx == 3'd3 && m_cnt == 1) && waited < 40) begin
            idle(1);
            waited++;
        end
        check_val("wait_digit3", {31'h0, (waited < 40)}, 32'd1);
        cycle(1'b0, 1'b1, 32'h0000_6000);
        idle(36);

        // asynchronous reset mid-scan
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_led", {16'h0, led},     32'h0);
        check_val("mid_rst_an",  {24'h0, seg_an},  32'hFF);
        check_val("mid_rst_out", {24'h0, seg_out}, 32'hFF);
        idle(2);
        rst_n = 1'b1;
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
